// File: rtl/control_sequencer.sv
// Instruction register and microcoded control unit for the 8-bit bus computer.
// Steps fetch/execute T-states, decodes every datapath strobe and holds the jump flags.
module control_sequencer #(
    parameter int         T_STEPS = 5,
    parameter logic [3:0] HLT_OP  = 4'hF
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire  [7:0] bus,
    input  logic       carry_in,
    input  logic       zero_in,
    output logic       mi,
    output logic       ro,
    output logic       ri,
    output logic       ii,
    output logic       io,
    output logic       ai,
    output logic       ao,
    output logic       bi,
    output logic       eo,
    output logic       su,
    output logic       oi,
    output logic       ce,
    output logic       co,
    output logic       j,
    output logic       hlt,
    output logic [2:0] step,
    output logic [7:0] ir
);

    localparam logic [2:0] LAST_STEP = 3'(T_STEPS - 1);

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;

    logic [7:0] ir_q, ir_d;
    logic [2:0] step_q, step_d;
    logic       carry_q, carry_d;
    logic       zero_q, zero_d;
    logic       halted_q, halted_d;

    logic       fi;
    logic       halt_set;
    logic [3:0] op;

    assign op   = ir_q[7:4];
    assign step = step_q;
    assign ir   = ir_q;
    assign bus  = io ? {4'h0, ir_q[3:0]} : 8'hzz;

    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q     <= 8'h00;
            step_q   <= 3'd0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            step_q   <= step_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            halted_q <= halted_d;
        end
    end

    // Microcode decode: strobes are a pure function of opcode, step, flags and halt.
    always_comb begin
        mi = 1'b0; ro = 1'b0; ri = 1'b0; ii = 1'b0; io = 1'b0;
        ai = 1'b0; ao = 1'b0; bi = 1'b0; eo = 1'b0; su = 1'b0;
        oi = 1'b0; ce = 1'b0; co = 1'b0; j  = 1'b0; hlt = 1'b0;
        fi = 1'b0;
        halt_set = 1'b0;
        if (!reset) begin
            if (halted_q) begin
                hlt = 1'b1;
            end else begin
                case (step_q)
                    3'd0: begin co = 1'b1; mi = 1'b1; end
                    3'd1: begin ro = 1'b1; ii = 1'b1; ce = 1'b1; end
                    3'd2: begin
                        if (op == HLT_OP) begin
                            hlt      = 1'b1;
                            halt_set = 1'b1;
                        end else begin
                            case (op)
                                OP_LDA, OP_ADD, OP_SUB, OP_STA: begin io = 1'b1; mi = 1'b1; end
                                OP_LDI: begin io = 1'b1; ai = 1'b1; end
                                OP_JMP: begin io = 1'b1; j = 1'b1; end
                                OP_JC:  begin io = carry_q; j = carry_q; end
                                OP_JZ:  begin io = zero_q;  j = zero_q;  end
                                OP_OUT: begin ao = 1'b1; oi = 1'b1; end
                                default: ;
                            endcase
                        end
                    end
                    3'd3: begin
                        case (op)
                            OP_LDA:         begin ro = 1'b1; ai = 1'b1; end
                            OP_ADD, OP_SUB: begin ro = 1'b1; bi = 1'b1; end
                            OP_STA:         begin ao = 1'b1; ri = 1'b1; end
                            default: ;
                        endcase
                    end
                    3'd4: begin
                        if (op == OP_ADD || op == OP_SUB) begin
                            eo = 1'b1;
                            ai = 1'b1;
                            fi = 1'b1;
                            su = (op == OP_SUB);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // The edge that sets halted also freezes step, so it stays parked at T2.
    always_comb begin
        ir_d     = ii ? bus : ir_q;
        carry_d  = fi ? carry_in : carry_q;
        zero_d   = fi ? zero_in  : zero_q;
        halted_d = halted_q | halt_set;
        step_d   = step_q;
        if (!halted_q && !halt_set) begin
            step_d = (step_q == LAST_STEP) ? 3'd0 : step_q + 3'd1;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: table of single instructions plus reset and halt sequences.
module tb_control_sequencer;

    localparam logic [14:0] S_MI  = 15'h4000;
    localparam logic [14:0] S_RO  = 15'h2000;
    localparam logic [14:0] S_RI  = 15'h1000;
    localparam logic [14:0] S_II  = 15'h0800;
    localparam logic [14:0] S_IO  = 15'h0400;
    localparam logic [14:0] S_AI  = 15'h0200;
    localparam logic [14:0] S_AO  = 15'h0100;
    localparam logic [14:0] S_BI  = 15'h0080;
    localparam logic [14:0] S_EO  = 15'h0040;
    localparam logic [14:0] S_SU  = 15'h0020;
    localparam logic [14:0] S_OI  = 15'h0010;
    localparam logic [14:0] S_CE  = 15'h0008;
    localparam logic [14:0] S_CO  = 15'h0004;
    localparam logic [14:0] S_J   = 15'h0002;
    localparam logic [14:0] S_HLT = 15'h0001;

    typedef struct {
        logic [7:0]  op;
        logic        cin;
        logic        zin;
        logic [14:0] e2;
        logic [14:0] e3;
        logic [14:0] e4;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       carry_in = 1'b0;
    logic       zero_in = 1'b0;
    logic       tb_en = 1'b0;
    logic [7:0] tb_val = 8'h00;
    wire  [7:0] bus;
    logic mi, ro, ri, ii, io, ai, ao, bi, eo, su, oi, ce, co, j, hlt;
    logic [2:0] step;
    logic [7:0] ir;

    int total = 0;
    int bad = 0;
    vec_t vt[17];

    assign bus = tb_en ? tb_val : 8'hzz;

    always #5 clock = ~clock;

    control_sequencer #(.T_STEPS(5), .HLT_OP(4'hF)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .carry_in(carry_in), .zero_in(zero_in),
        .mi(mi), .ro(ro), .ri(ri), .ii(ii), .io(io), .ai(ai), .ao(ao),
        .bi(bi), .eo(eo), .su(su), .oi(oi), .ce(ce), .co(co), .j(j),
        .hlt(hlt), .step(step), .ir(ir)
    );

    function automatic logic [14:0] strobes();
        return {mi, ro, ri, ii, io, ai, ao, bi, eo, su, oi, ce, co, j, hlt};
    endfunction

    function automatic vec_t mk(logic [7:0] op, logic cin, logic zin,
                                logic [14:0] e2, logic [14:0] e3, logic [14:0] e4);
        vec_t v;
        v.op = op; v.cin = cin; v.zin = zin; v.e2 = e2; v.e3 = e3; v.e4 = e4;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered at a negedge inside T0; returns at the negedge inside the next T0.
    task automatic run_instr(input vec_t v, input string nm);
        tb_en = 1'b0; carry_in = v.cin; zero_in = v.zin;
        #1;
        chk({nm, " T0 step"}, 32'(step), 32'd0);
        chk({nm, " T0 strobes"}, 32'(strobes()), 32'(S_CO | S_MI));
        @(negedge clock);
        tb_en = 1'b1; tb_val = v.op;
        #1;
        chk({nm, " T1 step"}, 32'(step), 32'd1);
        chk({nm, " T1 strobes"}, 32'(strobes()), 32'(S_RO | S_II | S_CE));
        @(negedge clock);
        tb_en = 1'b0;
        #1;
        chk({nm, " ir"}, 32'(ir), 32'(v.op));
        chk({nm, " T2 strobes"}, 32'(strobes()), 32'(v.e2));
        if ((v.e2 & S_IO) != 15'h0)
            chk({nm, " T2 bus"}, 32'(bus), {28'h0, v.op[3:0]});
        @(negedge clock);
        #1;
        chk({nm, " T3 strobes"}, 32'(strobes()), 32'(v.e3));
        @(negedge clock);
        #1;
        chk({nm, " T4 step"}, 32'(step), 32'd4);
        chk({nm, " T4 strobes"}, 32'(strobes()), 32'(v.e4));
        @(negedge clock);
    endtask

    initial begin
        vt[0]  = mk(8'h57, 1'b0, 1'b0, S_IO | S_AI, 15'h0, 15'h0);
        vt[1]  = mk(8'h7C, 1'b0, 1'b0, 15'h0, 15'h0, 15'h0);
        vt[2]  = mk(8'h85, 1'b0, 1'b0, 15'h0, 15'h0, 15'h0);
        vt[3]  = mk(8'h2A, 1'b1, 1'b1, S_IO | S_MI, S_RO | S_BI, S_EO | S_AI);
        vt[4]  = mk(8'h7C, 1'b0, 1'b0, S_IO | S_J, 15'h0, 15'h0);
        vt[5]  = mk(8'h85, 1'b0, 1'b0, S_IO | S_J, 15'h0, 15'h0);
        vt[6]  = mk(8'h3A, 1'b0, 1'b0, S_IO | S_MI, S_RO | S_BI, S_EO | S_AI | S_SU);
        vt[7]  = mk(8'h7C, 1'b1, 1'b1, 15'h0, 15'h0, 15'h0);
        vt[8]  = mk(8'h1D, 1'b0, 1'b0, S_IO | S_MI, S_RO | S_AI, 15'h0);
        vt[9]  = mk(8'h4E, 1'b0, 1'b0, S_IO | S_MI, S_AO | S_RI, 15'h0);
        vt[10] = mk(8'hE0, 1'b0, 1'b0, S_AO | S_OI, 15'h0, 15'h0);
        vt[11] = mk(8'h61, 1'b0, 1'b0, S_IO | S_J, 15'h0, 15'h0);
        vt[12] = mk(8'h00, 1'b0, 1'b0, 15'h0, 15'h0, 15'h0);
        vt[13] = mk(8'hB3, 1'b0, 1'b0, 15'h0, 15'h0, 15'h0);
        vt[14] = mk(8'h20, 1'b0, 1'b1, S_IO | S_MI, S_RO | S_BI, S_EO | S_AI);
        vt[15] = mk(8'h7C, 1'b0, 1'b0, 15'h0, 15'h0, 15'h0);
        vt[16] = mk(8'h85, 1'b0, 1'b0, S_IO | S_J, 15'h0, 15'h0);

        // Reset held two cycles, released at a negedge; first fetch T0 follows.
        reset = 1'b1;
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        #1;
        chk("reset strobes", 32'(strobes()), 32'd0);
        reset = 1'b0;
        #1;
        chk("release ir", 32'(ir), 32'd0);
        for (int i = 0; i < 17; i++) run_instr(vt[i], $sformatf("vec%0d", i));

        // Mid-instruction reset during ADD T3 after flags were set.
        run_instr(mk(8'h2F, 1'b1, 1'b1, S_IO | S_MI, S_RO | S_BI, S_EO | S_AI), "add pre");
        carry_in = 1'b0; zero_in = 1'b0;
        @(negedge clock); tb_en = 1'b1; tb_val = 8'h21;
        @(negedge clock); tb_en = 1'b0;
        @(negedge clock);
        #1;
        chk("mid T3 step", 32'(step), 32'd3);
        reset = 1'b1; tb_en = 1'b1; tb_val = 8'hA5;
        #1;
        chk("mid rst strobes", 32'(strobes()), 32'd0);
        chk("mid rst bus", 32'(bus), 32'hA5);
        @(negedge clock);
        #1;
        chk("mid rst step", 32'(step), 32'd0);
        chk("mid rst ir", 32'(ir), 32'd0);
        @(negedge clock);
        reset = 1'b0; tb_en = 1'b0;
        run_instr(mk(8'h7C, 1'b1, 1'b1, 15'h0, 15'h0, 15'h0), "jc after rst");
        run_instr(mk(8'h85, 1'b1, 1'b1, 15'h0, 15'h0, 15'h0), "jz after rst");

        // Halt: T2 raises hlt, then the machine parks at step 2.
        #1;
        chk("hlt T0 step", 32'(step), 32'd0);
        @(negedge clock); tb_en = 1'b1; tb_val = 8'hF0;
        @(negedge clock); tb_en = 1'b0;
        #1;
        chk("hlt T2 strobes", 32'(strobes()), 32'(S_HLT));
        chk("hlt T2 step", 32'(step), 32'd2);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            #1;
            chk($sformatf("halted%0d strobes", k), 32'(strobes()), 32'(S_HLT));
            chk($sformatf("halted%0d step", k), 32'(step), 32'd2);
        end
        chk("halted ir", 32'(ir), 32'hF0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("unhalt step", 32'(step), 32'd0);
        chk("unhalt strobes", 32'(strobes()), 32'(S_CO | S_MI));
        @(negedge clock);
        #1;
        chk("unhalt T1 step", 32'(step), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
